// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM FIFO controller: default widths and the
// burst FSM state encoding.
package sdram_pkg;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 24;
    localparam int BST_W       = 10;
    localparam int DEF_FIFO_AW = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_e;
endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level count. A pop on an
// empty FIFO only takes effect together with a push, which then passes through.
module sdram_sync_fifo #(
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [FIFO_AW:0]  level
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [FIFO_AW:0]  wr_ptr_r;
    logic [FIFO_AW:0]  rd_ptr_r;
    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;

    // Level, flags, accepted push/pop and fall-through head
    always_comb begin
        level   = wr_ptr_r - rd_ptr_r;
        empty_s = (level == (FIFO_AW+1)'(0));
        full_s  = (level == (FIFO_AW+1)'(DEPTH));
        push_s  = wr_en & (~full_s | rd_en);
        pop_s   = rd_en & (~empty_s | wr_en);
        rd_data = empty_s ? wr_data : mem_r[rd_ptr_r[FIFO_AW-1:0]];
    end

    // Pointer registers; reset discards all contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= (FIFO_AW+1)'(0);
            rd_ptr_r <= (FIFO_AW+1)'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + (FIFO_AW+1)'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + (FIFO_AW+1)'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r[FIFO_AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/sdram_fifo_ctrl.sv
// Bridges user write/read FIFOs to an SDRAM controller with burst requests
// over circular write and read address regions.
module sdram_fifo_ctrl
    import sdram_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int FIFO_AW = DEF_FIFO_AW
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              wr_fifo_wr_en,
    input  logic [DATA_W-1:0] wr_fifo_wr_data,
    output logic              wr_fifo_full,
    input  logic              rd_fifo_rd_en,
    output logic [DATA_W-1:0] rd_fifo_rd_data,
    output logic              rd_fifo_empty,
    input  logic [ADDR_W-1:0] wr_b_addr,
    input  logic [ADDR_W-1:0] wr_e_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    input  logic [ADDR_W-1:0] rd_e_addr,
    input  logic [BST_W-1:0]  wr_bst_len,
    input  logic [BST_W-1:0]  rd_bst_len,
    input  logic              rd_valid,
    input  logic              init_end,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [DATA_W-1:0] sdram_wr_data,
    input  logic              sdram_wr_ack,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic              sdram_rd_ack,
    input  logic [DATA_W-1:0] sdram_rd_data
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LVL_W = FIFO_AW + 1;
    localparam int CMP_W = ((LVL_W > BST_W) ? LVL_W : BST_W) + 1;

    state_e            state_r, next_state_s;
    logic [LVL_W-1:0]  wr_level_s, rd_level_s;
    logic [CMP_W-1:0]  rd_free_s;
    logic              wr_go_s, rd_go_s, wr_end_s, rd_end_s;
    logic              wr_req_r, rd_req_r, wr_req_nxt_s, rd_req_nxt_s;
    logic              wr_ack_d_r, rd_ack_d_r, addr_load_r;
    logic [ADDR_W-1:0] wr_addr_r, rd_addr_r;

    sdram_sync_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_wr_fifo (
        .clk(sdram_clk), .rst(sdram_rst),
        .wr_en(wr_fifo_wr_en), .wr_data(wr_fifo_wr_data),
        .rd_en(sdram_wr_ack), .rd_data(sdram_wr_data), .level(wr_level_s)
    );

    sdram_sync_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_rd_fifo (
        .clk(sdram_clk), .rst(sdram_rst),
        .wr_en(sdram_rd_ack), .wr_data(sdram_rd_data),
        .rd_en(rd_fifo_rd_en), .rd_data(rd_fifo_rd_data), .level(rd_level_s)
    );

    // Carry-safe advance of a burst address, wrapping to base at or past end
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr, input logic [BST_W-1:0] len,
        input logic [ADDR_W-1:0] b_addr, input logic [ADDR_W-1:0] e_addr);
        logic [ADDR_W:0] sum;
        sum = {1'b0, addr} + (ADDR_W+1)'(len);
        return (sum >= {1'b0, e_addr}) ? b_addr : sum[ADDR_W-1:0];
    endfunction

    assign wr_fifo_full  = (wr_level_s == LVL_W'(DEPTH));
    assign rd_fifo_empty = (rd_level_s == LVL_W'(0));
    assign rd_free_s     = CMP_W'(DEPTH) - CMP_W'(rd_level_s);
    assign wr_go_s       = init_end & (CMP_W'(wr_level_s) >= CMP_W'(wr_bst_len));
    assign rd_go_s       = init_end & rd_valid & (rd_free_s >= CMP_W'(rd_bst_len));
    // A burst ends on the falling edge of its ack
    assign wr_end_s      = (state_r == ST_WR) & wr_ack_d_r & ~sdram_wr_ack;
    assign rd_end_s      = (state_r == ST_RD) & rd_ack_d_r & ~sdram_rd_ack;

    assign sdram_wr_req  = wr_req_r;
    assign sdram_rd_req  = rd_req_r;
    assign sdram_wr_addr = wr_addr_r;
    assign sdram_rd_addr = rd_addr_r;

    // FSM state register
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) state_r <= ST_IDLE;
        else           state_r <= next_state_s;
    end

    // Next-state logic; write has priority over read
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_go_s)      next_state_s = ST_WR;
                else if (rd_go_s) next_state_s = ST_RD;
                else              next_state_s = ST_IDLE;
            end
            ST_WR:   next_state_s = wr_end_s ? ST_IDLE : ST_WR;
            ST_RD:   next_state_s = rd_end_s ? ST_IDLE : ST_RD;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Request set on burst entry, cleared after the first ack cycle
    always_comb begin
        wr_req_nxt_s = wr_req_r;
        rd_req_nxt_s = rd_req_r;
        if ((state_r == ST_IDLE) && (next_state_s == ST_WR)) wr_req_nxt_s = 1'b1;
        else if (sdram_wr_ack)                              wr_req_nxt_s = 1'b0;
        else                                                wr_req_nxt_s = wr_req_r;
        if ((state_r == ST_IDLE) && (next_state_s == ST_RD)) rd_req_nxt_s = 1'b1;
        else if (sdram_rd_ack)                              rd_req_nxt_s = 1'b0;
        else                                                rd_req_nxt_s = rd_req_r;
    end

    // Request, ack history and burst address registers
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            wr_req_r    <= 1'b0;
            rd_req_r    <= 1'b0;
            wr_ack_d_r  <= 1'b0;
            rd_ack_d_r  <= 1'b0;
            addr_load_r <= 1'b1;
            wr_addr_r   <= ADDR_W'(0);
            rd_addr_r   <= ADDR_W'(0);
        end else begin
            wr_req_r   <= wr_req_nxt_s;
            rd_req_r   <= rd_req_nxt_s;
            wr_ack_d_r <= sdram_wr_ack;
            rd_ack_d_r <= sdram_rd_ack;
            // Base addresses are not constants, so they load on the first clock
            if (addr_load_r) begin
                addr_load_r <= 1'b0;
                wr_addr_r   <= wr_b_addr;
                rd_addr_r   <= rd_b_addr;
            end else begin
                if (wr_end_s) wr_addr_r <= next_addr(wr_addr_r, wr_bst_len, wr_b_addr, wr_e_addr);
                else          wr_addr_r <= wr_addr_r;
                if (rd_end_s) rd_addr_r <= next_addr(rd_addr_r, rd_bst_len, rd_b_addr, rd_e_addr);
                else          rd_addr_r <= rd_addr_r;
            end
        end
    end
endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Self-checking bench for sdram_fifo_ctrl: scoreboard queues for both data
// paths, a table of write bursts and directed multi-cycle sequences.
module tb_sdram_fifo_ctrl;
    import sdram_pkg::*;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst;
    logic        wr_fifo_wr_en, rd_fifo_rd_en, rd_valid, init_end;
    logic [15:0] wr_fifo_wr_data, rd_fifo_rd_data, sdram_wr_data, sdram_rd_data;
    logic        wr_fifo_full, rd_fifo_empty;
    logic [23:0] wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr;
    logic [9:0]  wr_bst_len, rd_bst_len;
    logic        sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [15:0] wq[$];
    logic [15:0] rq[$];

    typedef struct {
        int          len;
        logic [23:0] exp_addr;
    } wr_vec_t;
    wr_vec_t tab[5];

    always #5 sdram_clk = ~sdram_clk;

    sdram_fifo_ctrl #(.DATA_W(16), .ADDR_W(24), .FIFO_AW(4)) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .wr_fifo_wr_en(wr_fifo_wr_en), .wr_fifo_wr_data(wr_fifo_wr_data),
        .wr_fifo_full(wr_fifo_full),
        .rd_fifo_rd_en(rd_fifo_rd_en), .rd_fifo_rd_data(rd_fifo_rd_data),
        .rd_fifo_empty(rd_fifo_empty),
        .wr_b_addr(wr_b_addr), .wr_e_addr(wr_e_addr),
        .rd_b_addr(rd_b_addr), .rd_e_addr(rd_e_addr),
        .wr_bst_len(wr_bst_len), .rd_bst_len(rd_bst_len),
        .rd_valid(rd_valid), .init_end(init_end),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr),
        .sdram_wr_data(sdram_wr_data), .sdram_wr_ack(sdram_wr_ack),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr),
        .sdram_rd_ack(sdram_rd_ack), .sdram_rd_data(sdram_rd_data)
    );

    // Acks are only legal inside the matching burst state
    a_wr_ack: assert property (@(posedge sdram_clk) disable iff (sdram_rst)
        sdram_wr_ack |-> (dut.state_r == ST_WR))
        else begin miss_cnt++; $display("FAIL wr_ack_state: ack in state %0d, required %0d", dut.state_r, ST_WR); end
    a_rd_ack: assert property (@(posedge sdram_clk) disable iff (sdram_rst)
        sdram_rd_ack |-> (dut.state_r == ST_RD))
        else begin miss_cnt++; $display("FAIL rd_ack_state: ack in state %0d, required %0d", dut.state_r, ST_RD); end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic wait_req(input bit rd, input string name);
        int c = 0;
        while (!(rd ? sdram_rd_req : sdram_wr_req) && c < 20) begin
            tick();
            c++;
        end
        check(name, rd ? sdram_rd_req : sdram_wr_req, 1'b1);
    endtask

    task automatic wr_push(input int n);
        for (int i = 0; i < n; i++) begin
            wr_fifo_wr_en   = 1'b1;
            wr_fifo_wr_data = 16'($urandom);
            wq.push_back(wr_fifo_wr_data);
            tick();
        end
        wr_fifo_wr_en = 1'b0;
    endtask

    task automatic wr_acks(input int len, input bit push_first);
        for (int i = 0; i < len; i++) begin
            sdram_wr_ack = 1'b1;
            if (push_first && i == 0) begin
                wr_fifo_wr_en   = 1'b1;
                wr_fifo_wr_data = 16'($urandom);
                wq.push_back(wr_fifo_wr_data);
            end
            #1;
            check("wr_data", sdram_wr_data, wq.pop_front());
            tick();
            wr_fifo_wr_en = 1'b0;
            if (push_first && i == 0) check("wr_full_push_pop", wr_fifo_full, 1'b1);
        end
        sdram_wr_ack = 1'b0;
        check("wr_req_drop", sdram_wr_req, 1'b0);
        tick();
        check("wr_end_idle", dut.state_r, ST_IDLE);
    endtask

    task automatic rd_burst(input int len, input logic [23:0] exp_addr, input bit pop_first);
        logic [15:0] d;
        wait_req(1'b1, "rd_req");
        check("rd_addr", sdram_rd_addr, exp_addr);
        for (int i = 0; i < len; i++) begin
            d = 16'($urandom);
            sdram_rd_ack  = 1'b1;
            sdram_rd_data = d;
            if (pop_first && i == 0) begin
                rd_fifo_rd_en = 1'b1;
                #1;
                check("rd_bypass_data", rd_fifo_rd_data, d);
            end else begin
                rq.push_back(d);
            end
            tick();
            rd_fifo_rd_en = 1'b0;
            if (pop_first && i == 0) check("rd_empty_push_pop", rd_fifo_empty, 1'b1);
        end
        sdram_rd_ack = 1'b0;
        rd_valid     = 1'b0;
        check("rd_req_drop", sdram_rd_req, 1'b0);
        tick();
        check("rd_end_idle", dut.state_r, ST_IDLE);
    endtask

    task automatic rd_pop(input int n);
        for (int i = 0; i < n; i++) begin
            check("rd_data", rd_fifo_rd_data, rq.pop_front());
            rd_fifo_rd_en = 1'b1;
            tick();
            rd_fifo_rd_en = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required $finish");
        $fatal(1);
    end

    initial begin
        tab[0] = '{8, 24'h8};
        tab[1] = '{8, 24'h0};
        tab[2] = '{4, 24'h8};
        tab[3] = '{4, 24'hC};
        tab[4] = '{4, 24'h0};

        sdram_rst = 1'b1; wr_fifo_wr_en = 1'b0; wr_fifo_wr_data = 16'h0;
        rd_fifo_rd_en = 1'b0; rd_valid = 1'b0; init_end = 1'b1;
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_rd_data = 16'h0;
        wr_b_addr = 24'h0; wr_e_addr = 24'h10; rd_b_addr = 24'h100; rd_e_addr = 24'h200;
        wr_bst_len = 10'd8; rd_bst_len = 10'd4;
        repeat (3) @(posedge sdram_clk);
        #1;
        check("rst_wr_req", sdram_wr_req, 1'b0);
        check("rst_rd_req", sdram_rd_req, 1'b0);
        check("rst_wr_full", wr_fifo_full, 1'b0);
        check("rst_rd_empty", rd_fifo_empty, 1'b1);
        check("rst_state", dut.state_r, ST_IDLE);
        sdram_rst = 1'b0;
        tick();
        check("init_wr_addr", sdram_wr_addr, 24'h0);
        check("init_rd_addr", sdram_rd_addr, 24'h100);

        // Write trigger: 7 words are not enough, the 8th starts a burst
        wr_push(7);
        repeat (3) begin
            check("wr_req_below_len", sdram_wr_req, 1'b0);
            tick();
        end
        wr_push(1);
        check("wr_req_early", sdram_wr_req, 1'b0);
        tick();
        check("wr_req_latency", sdram_wr_req, 1'b1);
        check("wr_addr_first", sdram_wr_addr, 24'h0);
        wr_acks(8, 1'b0);

        // Write bursts with region wrap at 16
        for (int i = 0; i < 5; i++) begin
            wr_bst_len = 10'(tab[i].len);
            wr_push(tab[i].len);
            wait_req(1'b0, "wr_req_tab");
            check("wr_addr_tab", sdram_wr_addr, tab[i].exp_addr);
            wr_acks(tab[i].len, 1'b0);
        end

        // Read prefetch, first word popped while pushed into the empty FIFO
        rd_valid = 1'b1;
        rd_burst(4, 24'h100, 1'b1);
        rd_valid = 1'b1;
        rd_burst(4, 24'h104, 1'b0);
        rd_pop(7);
        check("rd_empty_drained", rd_fifo_empty, 1'b1);

        // No requests before init_end; then both eligible at once, write first
        init_end = 1'b0; wr_bst_len = 10'd4; rd_bst_len = 10'd4; rd_valid = 1'b1;
        wr_push(4);
        repeat (3) begin
            check("noinit_wr_req", sdram_wr_req, 1'b0);
            check("noinit_rd_req", sdram_rd_req, 1'b0);
            tick();
        end
        init_end = 1'b1;
        wait_req(1'b0, "both_wr_req");
        check("both_rd_req_blocked", sdram_rd_req, 1'b0);
        check("both_wr_addr", sdram_wr_addr, 24'h4);
        wr_acks(4, 1'b0);
        check("gap_rd_req", sdram_rd_req, 1'b0);
        tick();
        check("after_gap_rd_req", sdram_rd_req, 1'b1);
        rd_burst(4, 24'h108, 1'b0);

        // Read FIFO with 3 free words holds off a 4-word prefetch
        rd_bst_len = 10'd9; rd_valid = 1'b1;
        rd_burst(9, 24'h10C, 1'b0);
        rd_bst_len = 10'd4; rd_valid = 1'b1;
        repeat (8) begin
            check("rd_full_no_req", sdram_rd_req, 1'b0);
            tick();
        end
        rd_pop(1);
        rd_burst(4, 24'h115, 1'b0);
        rd_pop(16);
        check("rd_empty_final", rd_fifo_empty, 1'b1);

        // Write FIFO full: extra push dropped, push+pop at full keeps level
        init_end = 1'b0; wr_bst_len = 10'd16;
        wr_push(16);
        check("wr_full", wr_fifo_full, 1'b1);
        wr_fifo_wr_en = 1'b1; wr_fifo_wr_data = 16'hDEAD;
        tick();
        wr_fifo_wr_en = 1'b0;
        check("wr_full_hold", wr_fifo_full, 1'b1);
        init_end = 1'b1;
        wait_req(1'b0, "wr_req_full");
        check("wr_addr_full", sdram_wr_addr, 24'h8);
        wr_acks(16, 1'b1);

        // Reset mid-burst with ack high
        wr_push(15);
        wait_req(1'b0, "wr_req_rst");
        check("wr_addr_rst", sdram_wr_addr, 24'h0);
        check("wr_full_pre_rst", wr_fifo_full, 1'b1);
        sdram_wr_ack = 1'b1;
        wr_b_addr    = 24'h20;
        #2;
        sdram_rst = 1'b1;
        #1;
        check("midrst_wr_req", sdram_wr_req, 1'b0);
        check("midrst_wr_full", wr_fifo_full, 1'b0);
        check("midrst_rd_empty", rd_fifo_empty, 1'b1);
        check("midrst_state", dut.state_r, ST_IDLE);
        sdram_wr_ack = 1'b0;
        #1;
        sdram_rst = 1'b0;
        wq.delete();
        tick();
        check("rerst_wr_addr", sdram_wr_addr, 24'h20);
        check("rerst_rd_addr", sdram_rd_addr, 24'h100);
        check("rerst_wr_req", sdram_wr_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
